// File: rtl/mult_pkg.sv
// Shared types and constants for the add/shift multiplier sequencer.
package mult_pkg;

    localparam int N_BITS_DEFAULT = 8;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ADD,
        SHIFT,
        HOLD
    } state_t;

endpackage

// File: rtl/mult_sequencer_if.sv
// Handshake and datapath-strobe bundle between the sequencer and its datapath.
interface mult_sequencer_if;

    logic Load_Clear;
    logic Run;
    logic M;
    logic Clr_Ld;
    logic Clr_XA;
    logic Add;
    logic Sub;
    logic Shift;
    logic Busy;
    logic Done;

    modport master (
        output Load_Clear, Run, M,
        input  Clr_Ld, Clr_XA, Add, Sub, Shift, Busy, Done
    );

    modport slave (
        input  Load_Clear, Run, M,
        output Clr_Ld, Clr_XA, Add, Sub, Shift, Busy, Done
    );

endinterface

// File: rtl/iter_counter.sv
// Iteration counter for the multiply loop; saturates at N_BITS-1 instead of wrapping.
module iter_counter
    import mult_pkg::*;
#(
    parameter int N_BITS = N_BITS_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic last
);

    localparam int CNT_W = $clog2(N_BITS);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && !last) begin
            count <= count + 1'b1;
        end
    end

    assign last = (count == CNT_W'(N_BITS - 1));

endmodule

// File: rtl/mult_sequencer.sv
// Control FSM for a signed add/shift multiplier: CLEAR, then N_BITS ADD/SHIFT pairs, then HOLD.
module mult_sequencer
    import mult_pkg::*;
#(
    parameter int N_BITS = N_BITS_DEFAULT
) (
    input  logic            Clk,
    input  logic            Reset,
    mult_sequencer_if.slave bus
);

    state_t state;
    state_t state_nxt;

    logic clr_ld;
    logic clr_xa;
    logic add;
    logic sub;
    logic shift;
    logic busy;
    logic done;
    logic cnt_clear;
    logic cnt_inc;
    logic cnt_last;

    iter_counter #(
        .N_BITS(N_BITS)
    ) u_iter_counter (
        .clk  (Clk),
        .rst  (Reset),
        .clear(cnt_clear),
        .inc  (cnt_inc),
        .last (cnt_last)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Reset forces every strobe low combinationally, even before the state register returns to IDLE.
    always_comb begin
        state_nxt = state;
        clr_ld    = 1'b0;
        clr_xa    = 1'b0;
        add       = 1'b0;
        sub       = 1'b0;
        shift     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        cnt_clear = 1'b0;
        cnt_inc   = 1'b0;
        if (!Reset) begin
            case (state)
                IDLE: begin
                    clr_ld = bus.Load_Clear;
                    if (bus.Run && !bus.Load_Clear) begin
                        state_nxt = CLEAR;
                    end
                end
                CLEAR: begin
                    clr_xa    = 1'b1;
                    busy      = 1'b1;
                    cnt_clear = 1'b1;
                    state_nxt = ADD;
                end
                ADD: begin
                    // The final partial product carries the sign bit of B, so it is subtracted.
                    busy      = 1'b1;
                    add       = bus.M && !cnt_last;
                    sub       = bus.M && cnt_last;
                    state_nxt = SHIFT;
                end
                SHIFT: begin
                    shift = 1'b1;
                    busy  = 1'b1;
                    if (cnt_last) begin
                        state_nxt = HOLD;
                    end else begin
                        cnt_inc   = 1'b1;
                        state_nxt = ADD;
                    end
                end
                HOLD: begin
                    done = 1'b1;
                    if (!bus.Run) begin
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    assign bus.Clr_Ld = clr_ld;
    assign bus.Clr_XA = clr_xa;
    assign bus.Add    = add;
    assign bus.Sub    = sub;
    assign bus.Shift  = shift;
    assign bus.Busy   = busy;
    assign bus.Done   = done;

endmodule

// File: tb/tb_mult_sequencer.sv
// Scoreboard bench for mult_sequencer with a behavioural X:A:B datapath supplying M.
module tb_mult_sequencer;

    localparam int N = 8;

    logic Clk = 1'b0;
    logic Reset;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    mult_sequencer_if bus ();

    mult_sequencer #(
        .N_BITS(N)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    // Behavioural datapath: X (sign), A (accumulator), B (multiplier, LSB feeds M).
    logic         dp_x = 1'b0;
    logic [N-1:0] dp_a = '0;
    logic [N-1:0] dp_b = '0;
    logic [N-1:0] sw;
    logic [N-1:0] s_val;

    assign bus.M = dp_b[0];

    always @(posedge Clk) begin
        if (bus.Clr_Ld) begin
            dp_x <= 1'b0;
            dp_a <= '0;
            dp_b <= sw;
        end else if (bus.Clr_XA) begin
            dp_x <= 1'b0;
            dp_a <= '0;
        end else if (bus.Add) begin
            {dp_x, dp_a} <= {dp_a[N-1], dp_a} + {s_val[N-1], s_val};
        end else if (bus.Sub) begin
            {dp_x, dp_a} <= {dp_a[N-1], dp_a} - {s_val[N-1], s_val};
        end else if (bus.Shift) begin
            dp_a <= {dp_x, dp_a[N-1:1]};
            dp_b <= {dp_a[0], dp_b[N-1:1]};
        end
    end

    // Scoreboard queues: per-cycle strobe vectors, run start cycles, final products.
    logic [6:0]   exp_q[$];
    int           start_q[$];
    logic [2*N:0] prod_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [6:0] outs();
        return {bus.Clr_Ld, bus.Clr_XA, bus.Add, bus.Sub, bus.Shift, bus.Busy, bus.Done};
    endfunction

    // Expected trace from the multiply rules: one CLEAR, per bit an add/sub/idle step and a shift, then HOLD.
    task automatic push_run(input logic [N-1:0] b, input logic [N-1:0] s, input int start);
        logic signed [N-1:0] bs;
        logic signed [N-1:0] ss;
        logic signed [2*N:0] p;
        start_q.push_back(start);
        exp_q.push_back(7'b0100010);
        for (int i = 0; i < N; i++) begin
            if (!b[i])           exp_q.push_back(7'b0000010);
            else if (i == N - 1) exp_q.push_back(7'b0001010);
            else                 exp_q.push_back(7'b0010010);
            exp_q.push_back(7'b0000110);
        end
        exp_q.push_back(7'b0000001);
        bs = b;
        ss = s;
        p  = ss * bs;
        prod_q.push_back(p);
    endtask

    // Monitor: pops on every busy cycle and on the first HOLD cycle.
    logic done_d = 1'b0;
    int   clear_cyc = 0;

    always @(negedge Clk) begin
        if (!Reset) begin
            if (bus.Clr_XA) begin
                if (start_q.size() == 0) chk("unexpected_clear", 1, 0);
                else chk("clear_cycle", cyc, start_q.pop_front());
                clear_cyc = cyc;
            end
            if (bus.Busy || (bus.Done && !done_d)) begin
                if (exp_q.size() == 0) chk("unexpected_activity", {25'd0, outs()}, 0);
                else chk("strobes", {25'd0, outs()}, {25'd0, exp_q.pop_front()});
            end
            if (bus.Done && !done_d) begin
                chk("latency", cyc - clear_cyc, 1 + 2 * N);
                if (prod_q.size() == 0) chk("unexpected_done", 1, 0);
                else chk("product", {dp_x, dp_a, dp_b}, prod_q.pop_front());
            end
        end
        done_d <= bus.Done;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_done(input bit disturb);
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            tick();
            if (bus.Done) seen = 1'b1;
            else if (disturb) begin
                bus.Run        = 1'($urandom_range(0, 1));
                bus.Load_Clear = 1'($urandom_range(0, 1));
            end
        end
        chk("done_reached", seen, 1);
    endtask

    task automatic finish_run();
        bus.Run        = 1'b0;
        bus.Load_Clear = 1'b0;
        tick();
        chk("hold_exit", {bus.Busy, bus.Done}, 0);
    endtask

    task automatic load_b(input logic [N-1:0] v);
        sw             = v;
        bus.Load_Clear = 1'b1;
        tick();
        bus.Load_Clear = 1'b0;
        chk("load_b", dp_b, v);
    endtask

    task automatic pulse_run();
        bus.Run = 1'b1;
        push_run(dp_b, s_val, cyc + 1);
        tick();
        bus.Run = 1'b0;
    endtask

    initial begin
        int n;
        Reset          = 1'b1;
        bus.Load_Clear = 1'b1;
        bus.Run        = 1'b0;
        sw             = '0;
        s_val          = N'($urandom);

        // Reset state, then Run already high when reset releases; B is zero.
        repeat (2) begin
            tick();
            chk("reset_outs", {25'd0, outs()}, 0);
        end
        bus.Load_Clear = 1'b0;
        bus.Run        = 1'b1;
        tick();
        chk("reset_outs_run", {25'd0, outs()}, 0);
        Reset = 1'b0;
        push_run(dp_b, s_val, cyc + 1);
        wait_done(1'b0);
        finish_run();

        // Load_Clear has priority over Run in IDLE.
        bus.Load_Clear = 1'b1;
        bus.Run        = 1'b1;
        sw             = 8'h81;
        repeat (3) begin
            tick();
            chk("lc_priority", {bus.Clr_Ld, bus.Clr_XA, bus.Busy}, 3'b100);
        end
        s_val          = N'($urandom);
        bus.Load_Clear = 1'b0;
        push_run(8'h81, s_val, cyc + 1);
        wait_done(1'b0);
        finish_run();

        // 7 * -3 = -21, with a Load_Clear pulse in HOLD.
        s_val = 8'h07;
        load_b(8'hFD);
        bus.Run = 1'b1;
        push_run(8'hFD, s_val, cyc + 1);
        wait_done(1'b0);
        sw             = 8'h55;
        bus.Load_Clear = 1'b1;
        #1;
        chk("hold_clr_ld", bus.Clr_Ld, 0);
        tick();
        chk("hold_lc_done", {bus.Busy, bus.Done}, 2'b01);
        chk("hold_lc_xab", {dp_x, dp_a, dp_b}, 32'h1FFEB);
        finish_run();

        // Run held for 40 cycles: exactly one sequence.
        s_val = N'($urandom);
        load_b(N'($urandom));
        bus.Run = 1'b1;
        push_run(dp_b, s_val, cyc + 1);
        n = 0;
        repeat (40) begin
            tick();
            if (bus.Shift) n++;
        end
        chk("held_shifts", n, N);
        chk("held_done", {bus.Busy, bus.Done}, 2'b01);
        finish_run();
        tick();
        chk("held_no_restart", bus.Busy, 0);

        // Reset for two cycles starting in the fifth ADD.
        s_val = N'($urandom);
        load_b(N'($urandom));
        pulse_run();
        repeat (9) tick();
        Reset = 1'b1;
        exp_q.delete();
        prod_q.delete();
        #1;
        chk("midrun_rst_outs", {25'd0, outs()}, 0);
        repeat (2) begin
            tick();
            chk("midrun_rst_outs", {25'd0, outs()}, 0);
        end
        Reset = 1'b0;
        #1;
        chk("post_rst_idle", {25'd0, outs()}, 0);
        n = 0;
        repeat (6) begin
            tick();
            if (bus.Shift || bus.Busy) n++;
        end
        chk("post_rst_quiet", n, 0);

        // Randomised runs with Run/Load_Clear toggling while busy.
        for (int r = 0; r < 6; r++) begin
            s_val = N'($urandom);
            load_b(N'($urandom));
            repeat ($urandom_range(0, 3)) tick();
            pulse_run();
            wait_done(1'b1);
            finish_run();
        end

        chk("queues_drained", exp_q.size() + prod_q.size() + start_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
